// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer: state encoding, PS/2 set-2 codes
// and the default debounce length in frames.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_MAZE   = 2'd1,
    ST_BATTLE = 2'd2,
    ST_END    = 2'd3
  } game_state_t;

  localparam int DWELL_FRAMES_DEF = 4;

  // Prefix bytes
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  // START / END keys
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_R     = 8'h2D;

  // Arrow keys (E0-prefixed)
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Battle keys
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_J     = 8'h3B;
  localparam logic [7:0] SC_K     = 8'h42;
  localparam logic [7:0] SC_L     = 8'h4B;
  localparam logic [7:0] SC_I     = 8'h43;

  function automatic logic is_arrow(input logic [7:0] code);
    return (code == SC_UP) || (code == SC_DOWN) ||
           (code == SC_LEFT) || (code == SC_RIGHT);
  endfunction

  function automatic logic is_battle_key(input logic [7:0] code);
    return (code == SC_W) || (code == SC_A) || (code == SC_S) || (code == SC_D) ||
           (code == SC_J) || (code == SC_K) || (code == SC_L) || (code == SC_I);
  endfunction

endpackage

// File: rtl/game_state_ctrl_ps2_key_assembler.sv
// Turns raw PS/2 set-2 bytes into complete key events. E0/F0 prefixes only set
// flags; any other byte completes a key, registered one cycle after its strobe.
module ps2_key_assembler
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  output logic       key_done,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic       ext_flag
);

  logic brk_flag;

  // Track prefixes and register the completed key; key_done is a one-cycle strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      key_done <= 1'b0;
      key_code <= 8'h00;
      key_ext  <= 1'b0;
      key_brk  <= 1'b0;
    end else begin
      key_done <= 1'b0;
      if (scan_valid) begin
        if (scan_code == SC_EXT) begin
          ext_flag <= 1'b1;
        end else if (scan_code == SC_BRK) begin
          brk_flag <= 1'b1;
        end else begin
          key_done <= 1'b1;
          key_code <= scan_code;
          key_ext  <= ext_flag;
          key_brk  <= brk_flag;
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Top-level game sequencer: START/MAZE/BATTLE/END FSM, key routing to the active
// screen, frame-edge detection, post-transition dwell and frame-aligned VGA select.
//
// Key strobes (maze_key_valid / battle_key_valid) are single-cycle pulses with
// no backpressure: they are valid for exactly the cycle in which key_code,
// key_ext and key_brk present the completed key, and consumers must take them then.
module game_state_ctrl
  import game_pkg::*;
#(
  parameter int DWELL_FRAMES = DWELL_FRAMES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scan_valid,
  input  logic [7:0] scan_code,
  input  logic       vs,
  input  logic       maze_done,
  input  logic       enc_hit,
  input  logic       battle_won,
  input  logic       battle_lost,
  output logic [1:0] game_state,
  output logic [1:0] vga_sel,
  output logic       maze_init,
  output logic       battle_init,
  output logic       maze_key_valid,
  output logic       battle_key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_brk,
  output logic [7:0] led
);

  localparam logic [7:0] DWELL_LOAD = 8'(DWELL_FRAMES);

  game_state_t state_q, state_d;
  logic        key_done;
  logic        key_make;
  logic        ext_flag;
  logic        vs_d;
  logic        vs_fall;
  logic [7:0]  dwell_cnt;
  logic        dwell_busy;
  logic        sel_pending;
  logic        trigger;

  ps2_key_assembler u_keys (
    .clk        (clk),
    .rst        (rst),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .key_done   (key_done),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_brk    (key_brk),
    .ext_flag   (ext_flag)
  );

  assign key_make   = key_done & ~key_brk;
  assign vs_fall    = vs_d & ~vs;
  assign dwell_busy = (dwell_cnt != 8'd0);
  assign trigger    = (state_d != state_q);
  assign game_state = state_q;
  assign led        = {3'b000, sel_pending, dwell_busy, ext_flag, game_state};

  // Next-state and key routing; routing uses the pre-transition state.
  always_comb begin
    state_d          = state_q;
    maze_key_valid   = 1'b0;
    battle_key_valid = 1'b0;
    case (state_q)
      ST_START: begin
        if (!dwell_busy && key_make && !key_ext && key_code == SC_ENTER)
          state_d = ST_MAZE;
      end
      ST_MAZE: begin
        if (key_make && key_ext && is_arrow(key_code))
          maze_key_valid = 1'b1;
        if (!dwell_busy) begin
          if (maze_done)    state_d = ST_END;
          else if (enc_hit) state_d = ST_BATTLE;
        end
      end
      ST_BATTLE: begin
        if (key_make && !key_ext && is_battle_key(key_code))
          battle_key_valid = 1'b1;
        if (!dwell_busy) begin
          if (battle_lost)     state_d = ST_END;
          else if (battle_won) state_d = ST_MAZE;
        end
      end
      ST_END: begin
        if (!dwell_busy && key_make && !key_ext && key_code == SC_R)
          state_d = ST_START;
      end
      default: state_d = ST_START;
    endcase
  end

  // State register plus entry pulses for the screen engines.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_START;
      maze_init   <= 1'b0;
      battle_init <= 1'b0;
    end else begin
      state_q     <= state_d;
      maze_init   <= trigger && (state_d == ST_MAZE);
      battle_init <= trigger && (state_d == ST_BATTLE);
    end
  end

  // Frame-edge detector; vs idles high so the history resets high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vs_d <= 1'b1;
    else      vs_d <= vs;
  end

  // Dwell counter: reload on any transition (wins over a coincident edge), else count frames down.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           dwell_cnt <= DWELL_LOAD;
    else if (trigger)                   dwell_cnt <= DWELL_LOAD;
    else if (vs_fall && dwell_busy)     dwell_cnt <= dwell_cnt - 8'd1;
  end

  // VGA select follows game_state only at a frame edge; a trigger defers the update to the next edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vga_sel     <= ST_START;
      sel_pending <= 1'b0;
    end else if (trigger) begin
      sel_pending <= 1'b1;
    end else if (sel_pending && vs_fall) begin
      vga_sel     <= state_q;
      sel_pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: reset values, key assembly and routing,
// dwell debounce, transition priorities and frame-aligned VGA select.
module tb_game_state_ctrl;

  logic       clk = 1'b0;
  logic       rst;

  // main instance (default dwell)
  logic       scan_valid, maze_done, enc_hit, battle_won, battle_lost, vs;
  logic [7:0] scan_code;
  logic [1:0] game_state, vga_sel;
  logic       maze_init, battle_init, maze_key_valid, battle_key_valid;
  logic [7:0] key_code, led;
  logic       key_ext, key_brk;

  // second instance with zero dwell, used for select retargeting
  logic       scan_valid0, enc_hit0, vs0;
  logic [7:0] scan_code0;
  logic [1:0] gs0, vga0;
  logic       mi0, bi0, mkv0, bkv0, ext0, brk0;
  logic [7:0] code0, led0;

  int n_tests = 0;
  int n_fail  = 0;
  int mi_cnt  = 0;
  int bi_cnt  = 0;
  int mkv_cnt = 0;
  int bkv_cnt = 0;
  int mkv_base, bkv_base;

  game_state_ctrl #(.DWELL_FRAMES(4)) u_dut (
    .clk(clk), .rst(rst), .scan_valid(scan_valid), .scan_code(scan_code), .vs(vs),
    .maze_done(maze_done), .enc_hit(enc_hit), .battle_won(battle_won),
    .battle_lost(battle_lost), .game_state(game_state), .vga_sel(vga_sel),
    .maze_init(maze_init), .battle_init(battle_init), .maze_key_valid(maze_key_valid),
    .battle_key_valid(battle_key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_brk(key_brk), .led(led)
  );

  game_state_ctrl #(.DWELL_FRAMES(0)) u_dut0 (
    .clk(clk), .rst(rst), .scan_valid(scan_valid0), .scan_code(scan_code0), .vs(vs0),
    .maze_done(1'b0), .enc_hit(enc_hit0), .battle_won(1'b0),
    .battle_lost(1'b0), .game_state(gs0), .vga_sel(vga0),
    .maze_init(mi0), .battle_init(bi0), .maze_key_valid(mkv0),
    .battle_key_valid(bkv0), .key_code(code0), .key_ext(ext0),
    .key_brk(brk0), .led(led0)
  );

  // clock
  always #5 clk = ~clk;

  // pulse counters (each count lands one cycle after the pulse)
  always @(posedge clk) begin
    if (maze_init)        mi_cnt  <= mi_cnt + 1;
    if (battle_init)      bi_cnt  <= bi_cnt + 1;
    if (maze_key_valid)   mkv_cnt <= mkv_cnt + 1;
    if (battle_key_valid) bkv_cnt <= bkv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // All driver tasks start and end at a falling clock edge.
  task automatic send_byte(input logic [7:0] b);
    scan_valid = 1'b1;
    scan_code  = b;
    @(negedge clk);
    scan_valid = 1'b0;
  endtask

  task automatic vs_edge();
    vs = 1'b0;
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
  endtask

  task automatic vs_edges(input int n);
    for (int i = 0; i < n; i++) vs_edge();
  endtask

  initial begin
    rst = 1'b0;
    scan_valid = 0; scan_code = 0; maze_done = 0; enc_hit = 0;
    battle_won = 0; battle_lost = 0; vs = 1;
    scan_valid0 = 0; scan_code0 = 0; enc_hit0 = 0; vs0 = 1;
    repeat (3) @(negedge clk);

    // reset values, and bytes ignored while held in reset
    check("rst_state", game_state, 2'd0);
    check("rst_vga", vga_sel, 2'd0);
    check("rst_led", led, 8'h08);
    check("rst_mkv", maze_key_valid, 1'b0);
    check("rst_minit", maze_init, 1'b0);
    send_byte(8'h5A);
    check("rst_key_code", key_code, 8'h00);
    rst = 1'b1;
    @(negedge clk);

    // zero-dwell instance: two transitions before one frame edge
    scan_valid0 = 1'b1; scan_code0 = 8'h5A;
    @(negedge clk);
    scan_valid0 = 1'b0;
    @(negedge clk);
    check("rt_state_maze", gs0, 2'd1);
    check("rt_vga_hold0", vga0, 2'd0);
    enc_hit0 = 1'b1;
    @(negedge clk);
    enc_hit0 = 1'b0;
    check("rt_state_battle", gs0, 2'd2);
    check("rt_vga_hold1", vga0, 2'd0);
    vs0 = 1'b0;
    @(negedge clk);
    vs0 = 1'b1;
    check("rt_vga_final", vga0, 2'd2);
    check("rt_led", led0, 8'h02);

    // Enter during reset dwell is ignored
    send_byte(8'h5A);
    check("k_code_5a", key_code, 8'h5A);
    @(negedge clk);
    check("dwell_start_hold", game_state, 2'd0);
    vs_edges(4);
    check("dwell_clear_led", led, 8'h00);

    // Enter -> MAZE
    send_byte(8'h5A);
    check("start_no_mkv", maze_key_valid, 1'b0);
    @(negedge clk);
    check("enter_state", game_state, 2'd1);
    check("enter_minit", maze_init, 1'b1);
    check("enter_vga_hold", vga_sel, 2'd0);
    check("enter_led", led, 8'h19);
    @(negedge clk);
    check("minit_one_cycle", maze_init, 1'b0);
    vs_edge();
    check("enter_vga", vga_sel, 2'd1);
    check("enter_led2", led, 8'h09);

    // enc_hit inside dwell ignored
    vs_edge();
    enc_hit = 1'b1;
    @(negedge clk);
    enc_hit = 1'b0;
    check("dwell_ignore_hit", game_state, 2'd1);
    vs_edges(2);
    check("maze_led_idle", led, 8'h01);

    // maze key routing
    mkv_base = mkv_cnt;
    bkv_base = bkv_cnt;
    send_byte(8'hE0);
    check("e0_flag", led, 8'h05);
    check("e0_no_strobe", maze_key_valid, 1'b0);
    send_byte(8'h75);
    check("up_mkv", maze_key_valid, 1'b1);
    check("up_code", key_code, 8'h75);
    check("up_ext", key_ext, 1'b1);
    check("up_brk", key_brk, 1'b0);
    check("up_bkv", battle_key_valid, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    check("up_rel_mkv", maze_key_valid, 1'b0);
    check("up_rel_ext", key_ext, 1'b1);
    check("up_rel_brk", key_brk, 1'b1);
    send_byte(8'h75);
    check("plain75_mkv", maze_key_valid, 1'b0);
    send_byte(8'hE0);
    send_byte(8'hE0);
    send_byte(8'h6B);
    check("left_mkv", maze_key_valid, 1'b1);
    check("left_ext", key_ext, 1'b1);
    @(negedge clk);
    check("maze_mkv_count", mkv_cnt - mkv_base, 2);
    check("maze_bkv_count", bkv_cnt - bkv_base, 0);

    // MAZE -> BATTLE
    enc_hit = 1'b1;
    @(negedge clk);
    enc_hit = 1'b0;
    check("hit_state", game_state, 2'd2);
    check("hit_binit", battle_init, 1'b1);
    vs_edge();
    check("hit_vga", vga_sel, 2'd2);

    // battle key routing
    send_byte(8'h1D);
    check("w_bkv", battle_key_valid, 1'b1);
    check("w_code", key_code, 8'h1D);
    check("w_mkv", maze_key_valid, 1'b0);
    send_byte(8'hF0);
    send_byte(8'h1D);
    check("w_rel_bkv", battle_key_valid, 1'b0);
    send_byte(8'hE0);
    send_byte(8'h75);
    check("battle_arrow_mkv", maze_key_valid, 1'b0);
    check("battle_arrow_bkv", battle_key_valid, 1'b0);
    send_byte(8'h42);
    check("k_bkv", battle_key_valid, 1'b1);
    vs_edges(3);

    // battle_won on the same cycle as a frame edge: select waits one more frame
    vs = 1'b0;
    battle_won = 1'b1;
    @(negedge clk);
    vs = 1'b1;
    battle_won = 1'b0;
    check("won_state", game_state, 2'd1);
    check("won_minit", maze_init, 1'b1);
    check("won_vga_hold", vga_sel, 2'd2);
    @(negedge clk);
    check("won_vga_hold2", vga_sel, 2'd2);
    vs_edge();
    check("won_vga", vga_sel, 2'd1);
    vs_edges(3);

    // maze_done wins over enc_hit
    enc_hit = 1'b1;
    maze_done = 1'b1;
    @(negedge clk);
    enc_hit = 1'b0;
    maze_done = 1'b0;
    check("done_state", game_state, 2'd3);
    check("done_binit", battle_init, 1'b0);
    vs_edge();
    check("done_vga", vga_sel, 2'd3);
    vs_edges(3);

    // END -> START on R
    send_byte(8'h2D);
    check("r_mkv", maze_key_valid, 1'b0);
    check("r_bkv", battle_key_valid, 1'b0);
    @(negedge clk);
    check("r_state", game_state, 2'd0);
    @(negedge clk);
    check("minit_total", mi_cnt, 2);
    check("binit_total", bi_cnt, 1);

    // reset after a lone E0 discards the prefix
    send_byte(8'hE0);
    check("mid_e0_flag", led[2], 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_led", led, 8'h08);
    check("mid_rst_code", key_code, 8'h00);
    check("mid_rst_vga", vga_sel, 2'd0);
    rst = 1'b1;
    @(negedge clk);
    send_byte(8'h75);
    check("post_rst_code", key_code, 8'h75);
    check("post_rst_ext", key_ext, 1'b0);
    check("post_rst_mkv", maze_key_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
